// File: rtl/ldpc_pkg.sv
// Shared LDPC message widths, field positions, bank states and the
// saturating magnitude subtract used by the check-node units.
package ldpc_pkg;
  localparam int VNU_MSG_W = 6;
  localparam int CNU_MSG_W = 5;
  localparam int MAG_W     = 4;
  localparam int HD_BIT    = 5;
  localparam int SGN_BIT   = 4;

  typedef enum logic {COL_FILL, COL_FULL} col_state_t;
  typedef enum logic {EMT_IDLE, EMT_BUSY} emt_state_t;

  function automatic logic [MAG_W-1:0] sm_sat_sub(input logic [MAG_W-1:0] mag,
                                                  input logic [MAG_W-1:0] off);
    return (mag > off) ? mag - off : '0;
  endfunction
endpackage

// File: rtl/cnu_minsum_serial_if.sv
// Edge-message streams between the VNU side and the serial CNU.
// The slave modport is the CNU, the master modport is its environment.
interface cnu_minsum_serial_if
  import ldpc_pkg::*;
#(
  parameter int DC = 6
) ();
  localparam int IW = (DC > 1) ? $clog2(DC) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [VNU_MSG_W-1:0] in_msg;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNU_MSG_W-1:0] out_msg;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic                 out_parity;

  modport slave (
    input  in_valid, in_msg, out_ready,
    output in_ready, out_valid, out_msg, out_idx, out_last, out_parity
  );

  modport master (
    output in_valid, in_msg, out_ready,
    input  in_ready, out_valid, out_msg, out_idx, out_last, out_parity
  );
endinterface

// File: rtl/cnu_min_fold.sv
// Folds one edge magnitude into the running (min1, min2, index-of-min1) triple.
// Strict compares keep the earliest index on ties and let an equal value become min2.
module cnu_min_fold
  import ldpc_pkg::*;
#(
  parameter int IW = 3
) (
  input  logic [MAG_W-1:0] min1,
  input  logic [MAG_W-1:0] min2,
  input  logic [IW-1:0]    idx,
  input  logic [MAG_W-1:0] mag,
  input  logic [IW-1:0]    pos,
  output logic [MAG_W-1:0] min1_nxt,
  output logic [MAG_W-1:0] min2_nxt,
  output logic [IW-1:0]    idx_nxt
);
  always_comb begin
    min1_nxt = min1;
    min2_nxt = min2;
    idx_nxt  = idx;
    if (mag < min1) begin
      min2_nxt = min1;
      min1_nxt = mag;
      idx_nxt  = pos;
    end else if (mag < min2) begin
      min2_nxt = mag;
    end
  end
endmodule

// File: rtl/cnu_minsum_serial.sv
// Serial offset-min-sum check node: collects DC edges into one bank while the
// other bank streams the check-to-variable messages, plus the check parity bit.
module cnu_minsum_serial
  import ldpc_pkg::*;
#(
  parameter int DC     = 6,
  parameter int OFFSET = 0
) (
  input logic               clk,
  input logic               rst,
  cnu_minsum_serial_if.slave bus
);
  localparam int IW = (DC > 1) ? $clog2(DC) : 1;
  localparam logic [IW-1:0]    LAST = IW'(DC - 1);
  localparam logic [MAG_W-1:0] OFF  = MAG_W'(OFFSET);

  col_state_t       col_st;
  logic [IW-1:0]    cnt;
  logic [MAG_W-1:0] c_min1, c_min2;
  logic [IW-1:0]    c_idx;
  logic             c_sgn, c_par;
  logic [DC-1:0]    c_signs;

  emt_state_t       emt_st;
  logic [IW-1:0]    e_pos;
  logic [MAG_W-1:0] e_min1, e_min2;
  logic [IW-1:0]    e_idx;
  logic             e_sgn, e_par;
  logic [DC-1:0]    e_signs;

  logic [MAG_W-1:0] f_min1, f_min2;
  logic [IW-1:0]    f_idx;
  logic [MAG_W-1:0] in_mag;
  logic             in_sgn, in_hd;
  logic             accept, beat, last_beat, xfer;
  logic [MAG_W-1:0] sel_mag;

  assign in_mag = bus.in_msg[MAG_W-1:0];
  assign in_sgn = bus.in_msg[SGN_BIT];
  assign in_hd  = bus.in_msg[HD_BIT];

  assign bus.in_ready = (col_st == COL_FILL) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign beat         = (emt_st == EMT_BUSY) && bus.out_ready;
  assign last_beat    = beat && (e_pos == LAST);
  // A full bank hands over when EMIT is idle or finishes in this very cycle.
  assign xfer         = (col_st == COL_FULL) && ((emt_st == EMT_IDLE) || last_beat);

  cnu_min_fold #(.IW(IW)) u_fold (
    .min1     (c_min1),
    .min2     (c_min2),
    .idx      (c_idx),
    .mag      (in_mag),
    .pos      (cnt),
    .min1_nxt (f_min1),
    .min2_nxt (f_min2),
    .idx_nxt  (f_idx)
  );

  always_ff @(posedge clk) begin
    if (rst || xfer) begin
      col_st  <= COL_FILL;
      cnt     <= '0;
      c_min1  <= '1;
      c_min2  <= '1;
      c_idx   <= '0;
      c_sgn   <= 1'b0;
      c_par   <= 1'b0;
      c_signs <= '0;
    end else if (accept) begin
      c_min1       <= f_min1;
      c_min2       <= f_min2;
      c_idx        <= f_idx;
      c_sgn        <= c_sgn ^ in_sgn;
      c_par        <= c_par ^ in_hd;
      c_signs[cnt] <= in_sgn;
      if (cnt == LAST) begin
        col_st <= COL_FULL;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      emt_st  <= EMT_IDLE;
      e_pos   <= '0;
      e_min1  <= '0;
      e_min2  <= '0;
      e_idx   <= '0;
      e_sgn   <= 1'b0;
      e_par   <= 1'b0;
      e_signs <= '0;
    end else if (xfer) begin
      emt_st  <= EMT_BUSY;
      e_pos   <= '0;
      e_min1  <= c_min1;
      e_min2  <= c_min2;
      e_idx   <= c_idx;
      e_sgn   <= c_sgn;
      e_par   <= c_par;
      e_signs <= c_signs;
    end else if (last_beat) begin
      emt_st <= EMT_IDLE;
      e_pos  <= '0;
    end else if (beat) begin
      e_pos <= e_pos + 1'b1;
    end
  end

  assign sel_mag        = (e_pos == e_idx) ? e_min2 : e_min1;
  assign bus.out_valid  = (emt_st == EMT_BUSY);
  assign bus.out_msg    = bus.out_valid ? {e_sgn ^ e_signs[e_pos], sm_sat_sub(sel_mag, OFF)} : '0;
  assign bus.out_idx    = e_pos;
  assign bus.out_last   = bus.out_valid && (e_pos == LAST);
  assign bus.out_parity = bus.out_valid && e_par;
endmodule

// File: tb/tb_cnu_minsum_serial.sv
// Bench for the serial min-sum CNU: two instances (OFFSET 0 and 3) share one
// stimulus stream and are scored against a leave-one-out min-sum reference.
module tb_cnu_minsum_serial;
  import ldpc_pkg::*;

  localparam int DC    = 6;
  localparam int OFF_B = 3;

  typedef struct {
    logic [4:0] m0;
    logic [4:0] m1;
    int         idx;
    logic       last;
    logic       par;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnu_minsum_serial_if #(.DC(DC)) bus0 ();
  cnu_minsum_serial_if #(.DC(DC)) bus1 ();

  cnu_minsum_serial #(.DC(DC), .OFFSET(0))     dut0 (.clk(clk), .rst(rst), .bus(bus0));
  cnu_minsum_serial #(.DC(DC), .OFFSET(OFF_B)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_msg    = bus0.in_msg;
  assign bus1.out_ready = bus0.out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  beat_t      expq[$];
  logic [5:0] txq[$];
  logic [5:0] part[$];

  logic acc_seen    = 1'b0;
  logic force_valid = 1'b0;
  logic stall       = 1'b0;
  int   vprob       = 100;
  int   rprob       = 100;
  int   lat_from    = -1;
  int   last_end    = -1;
  int   gap_exp     = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [5:0] mk_edge(input int hd, input int sg, input int mg);
    logic [5:0] e;
    e[5]   = hd[0];
    e[4]   = sg[0];
    e[3:0] = mg[3:0];
    return e;
  endfunction

  // Each edge receives the minimum magnitude and sign product of all other edges.
  task automatic model_frame();
    int    mn, mo;
    logic  sg, par;
    beat_t b;
    par = 1'b0;
    for (int k = 0; k < DC; k++) par ^= part[k][5];
    for (int j = 0; j < DC; j++) begin
      mn = 99;
      sg = 1'b0;
      for (int k = 0; k < DC; k++) begin
        if (k != j) begin
          if (int'(part[k][3:0]) < mn) mn = int'(part[k][3:0]);
          sg ^= part[k][4];
        end
      end
      mo     = (mn > OFF_B) ? mn - OFF_B : 0;
      b.m0   = {sg, 4'(mn)};
      b.m1   = {sg, 4'(mo)};
      b.idx  = j;
      b.last = (j == DC - 1);
      b.par  = par;
      expq.push_back(b);
    end
  endtask

  // Monitor: scores every valid output cycle against the queue head, then captures accepts.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        part.delete();
        acc_seen = 1'b0;
        lat_from = -1;
      end else begin
        if (bus0.out_valid) begin
          if (expq.size() == 0) begin
            check_eq("unexpected_beat", 1, 0);
          end else begin
            b = expq[0];
            check_eq("msg_off0", bus0.out_msg, b.m0);
            check_eq("msg_off3", bus1.out_msg, b.m1);
            check_eq("valid_off3", bus1.out_valid, 1);
            check_eq("out_idx", bus0.out_idx, b.idx);
            check_eq("out_last", bus0.out_last, b.last);
            check_eq("out_parity", bus0.out_parity, b.par);
            if (lat_from >= 0) begin
              check_eq("latency", cyc - lat_from, 2);
              lat_from = -1;
            end
            if (bus0.out_ready) begin
              if (b.idx == 0 && last_end >= 0 && gap_exp >= 0)
                check_eq("frame_gap", cyc - last_end - 1, gap_exp);
              if (b.last) last_end = cyc;
              void'(expq.pop_front());
            end
          end
        end
        acc_seen = bus0.in_valid && bus0.in_ready;
        if (acc_seen) begin
          part.push_back(bus0.in_msg);
          if (part.size() == DC) begin
            if (expq.size() == 0) lat_from = cyc;
            model_frame();
            part.delete();
          end
        end
      end
    end
  end

  // Driver: presents the head of txq, retires it once the monitor saw it accepted.
  initial begin
    bus0.in_valid  = 1'b0;
    bus0.in_msg    = '0;
    bus0.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      if (acc_seen && txq.size() > 0) void'(txq.pop_front());
      #1;
      if (force_valid) begin
        bus0.in_valid = 1'b1;
        bus0.in_msg   = 6'($urandom);
      end else if (txq.size() > 0 && $urandom_range(99) < vprob) begin
        bus0.in_valid = 1'b1;
        bus0.in_msg   = txq[0];
      end else begin
        bus0.in_valid = 1'b0;
        bus0.in_msg   = '0;
      end
      bus0.out_ready = !stall && ($urandom_range(99) < rprob);
    end
  end

  task automatic push_rand_frame();
    int m;
    for (int i = 0; i < DC; i++) begin
      m = ($urandom_range(3) == 0) ? 2 : int'($urandom_range(15));
      txq.push_back(mk_edge(int'($urandom_range(1)), int'($urandom_range(1)), m));
    end
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while ((txq.size() > 0 || expq.size() > 0 || part.size() > 0 || bus0.out_valid) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) check_eq("idle_timeout", t, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int bm[DC] = '{5, 3, 9, 3, 7, 12};
    int bs[DC] = '{0, 1, 0, 0, 1, 0};
    int bh[DC] = '{1, 0, 1, 1, 0, 0};
    int dm[DC] = '{8, 2, 6, 4, 15, 9};
    int om[DC] = '{1, 5, 5, 5, 5, 5};
    int t;

    rst         = 1'b1;
    force_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", bus0.in_ready, 0);
    check_eq("rst_in_ready_b", bus1.in_ready, 0);
    check_eq("rst_out_valid", bus0.out_valid, 0);
    check_eq("rst_out_msg", bus0.out_msg, 0);
    check_eq("rst_out_idx", bus0.out_idx, 0);
    check_eq("rst_out_last", bus0.out_last, 0);
    check_eq("rst_out_parity", bus0.out_parity, 0);
    force_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", bus0.in_ready, 1);
    check_eq("post_rst_out_valid", bus0.out_valid, 0);

    // basic frame, then distinct minimum, then offset floor
    for (int i = 0; i < DC; i++) txq.push_back(mk_edge(bh[i], bs[i], bm[i]));
    wait_idle(200);
    for (int i = 0; i < DC; i++) txq.push_back(mk_edge(0, 0, dm[i]));
    wait_idle(200);
    for (int i = 0; i < DC; i++) txq.push_back(mk_edge(int'($urandom_range(1)), 0, om[i]));
    wait_idle(200);

    // backpressure: stall frame A at beat 3 while frame B fills the collect bank
    last_end = -1;
    gap_exp  = 0;
    push_rand_frame();
    push_rand_frame();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus0.out_valid && bus0.out_idx == 3) && t < 200);
    if (t >= 200) check_eq("bp_wait_timeout", t, 0);
    stall = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("bp_in_ready", bus0.in_ready, 0);
    check_eq("bp_out_valid", bus0.out_valid, 1);
    stall = 1'b0;
    wait_idle(300);

    // back-to-back: continuous valid/ready, one transfer bubble per frame
    last_end = -1;
    gap_exp  = 1;
    repeat (4) push_rand_frame();
    wait_idle(400);

    // random handshake pressure
    gap_exp = -1;
    vprob   = 70;
    rprob   = 60;
    repeat (6) push_rand_frame();
    wait_idle(1000);
    vprob = 100;
    rprob = 100;

    // reset while emitting beat 3
    push_rand_frame();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus0.out_valid && bus0.out_idx == 3) && t < 200);
    if (t >= 200) check_eq("rst_emit_timeout", t, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_out_valid", bus0.out_valid, 0);
    check_eq("mid_rst_out_valid_b", bus1.out_valid, 0);
    check_eq("mid_rst_out_msg", bus0.out_msg, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("after_rst_out_valid", bus0.out_valid, 0);
    push_rand_frame();
    wait_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
